image_scan_ctrl: RTL

//  Upstream controller for the image ROM container: walks a frame in raster order, issues one

---
 rtl/image_scan_ctrl.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/image_scan_ctrl.sv
// image_scan_ctrl
//   Walks one image frame in raster order. For each pixel it issues a
//   single-cycle read request with the linear coordinate index. It then waits
//   for the image container's data strobe and presents the captured pixel
//   and its (x,y) position downstream over a valid/ready handshake. Only one
//   read is outstanding at a time. A missing strobe raises a sticky timeout
//   error and abandons the frame.
//
// Optional feature macro: FRAME_CHECKSUM_EN
//   When defined, the o_checksum port is added. It carries the mod-2^16 sum
//   of every pixel transferred in the current frame.
//
// Ports
//   clk                 in   system clock, rising edge
//   reset               in   synchronous reset, active low
//   start               in   pulse, begins a frame scan (only honoured in IDLE)
//   abort               in   pulse, drops the current frame and returns to IDLE
//   o_enable            out  one-cycle read request to the image container
//   o_coordinate_index  out  linear pixel index, valid with o_enable
//   i_pixel             in   pixel data from the container
//   i_pixel_strobe      in   container data-valid pulse
//   o_pixel             out  captured pixel
//   o_x / o_y           out  column / row of o_pixel
//   o_pixel_valid       out  o_pixel/o_x/o_y valid, held until accepted
//   i_ready             in   downstream accept
//   o_end_of_row        out  qualifies o_pixel_valid: last column
//   o_end_of_frame      out  qualifies o_pixel_valid: last pixel of frame
//   o_busy              out  high in every state except IDLE
//   o_error             out  sticky timeout flag, cleared by reset or start
//   o_checksum          out  (FRAME_CHECKSUM_EN only) running pixel sum
//
// state   | meaning
// IDLE    | no frame in progress
// ISSUE   | o_enable high for one cycle with current index
// WAIT    | read outstanding, timer running, waiting for strobe
// PRESENT | pixel valid downstream, waiting for i_ready
// DONE    | one-cycle frame completion, then IDLE
module image_scan_ctrl #(
  parameter int DATA_WIDTH_8   = 8,
  parameter int DATA_WIDTH_16  = 16,
  parameter int IMAGE_WIDTH    = 200,
  parameter int IMAGE_HEIGHT   = 150,
  parameter int TIMEOUT_CYCLES = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     abort,
  output logic                     o_enable,
  output logic [DATA_WIDTH_16-1:0] o_coordinate_index,
  input  logic [DATA_WIDTH_8-1:0]  i_pixel,
  input  logic                     i_pixel_strobe,
  output logic [DATA_WIDTH_8-1:0]  o_pixel,
  output logic [DATA_WIDTH_16-1:0] o_x,
  output logic [DATA_WIDTH_16-1:0] o_y,
  output logic                     o_pixel_valid,
  input  logic                     i_ready,
  output logic                     o_end_of_row,
  output logic                     o_end_of_frame,
  output logic                     o_busy,
  output logic                     o_error
`ifdef FRAME_CHECKSUM_EN
  ,
  output logic [15:0]              o_checksum
`endif
);

  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [DATA_WIDTH_16-1:0] X_LAST   = DATA_WIDTH_16'(IMAGE_WIDTH - 1);
  localparam logic [DATA_WIDTH_16-1:0] Y_LAST   = DATA_WIDTH_16'(IMAGE_HEIGHT - 1);
  localparam logic [DATA_WIDTH_16-1:0] ONE_16   = DATA_WIDTH_16'(1);
  localparam logic [TIMER_W-1:0]       TIMER_ONE = TIMER_W'(1);
  localparam logic [TIMER_W-1:0]       TIMER_TC  = TIMER_W'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT    = 3'd2,
    S_PRESENT = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [DATA_WIDTH_16-1:0] x_cnt, y_cnt, idx;
  logic [TIMER_W-1:0]       timer;
  logic [DATA_WIDTH_8-1:0]  pixel_q;
  logic [DATA_WIDTH_16-1:0] x_q, y_q;
  logic                     error;

  logic last_pixel;
  logic transfer;
  logic timer_tc;

  assign last_pixel = (x_q == X_LAST) && (y_q == Y_LAST);
  assign transfer   = (state == S_PRESENT) && i_ready;
  assign timer_tc   = (timer == TIMER_TC);

  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:    if (start) state_nxt = S_ISSUE;
        S_ISSUE:   state_nxt = S_WAIT;
        // A strobe landing on the terminal timer cycle still counts as a hit.
        S_WAIT: begin
          if (i_pixel_strobe) state_nxt = S_PRESENT;
          else if (timer_tc)  state_nxt = S_IDLE;
        end
        S_PRESENT: if (i_ready) state_nxt = last_pixel ? S_DONE : S_ISSUE;
        S_DONE:    state_nxt = S_IDLE;
        default:   state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    o_enable       = (state == S_ISSUE);
    o_pixel_valid  = (state == S_PRESENT);
    o_busy         = (state != S_IDLE);
    o_end_of_row   = (state == S_PRESENT) && (x_q == X_LAST);
    o_end_of_frame = (state == S_PRESENT) && last_pixel;
  end

  // The index is advanced together with x/y, so it always equals y*W + x
  // without needing a multiplier.
  always_ff @(posedge clk) begin
    if (!reset) begin
      x_cnt   <= '0;
      y_cnt   <= '0;
      idx     <= '0;
      timer   <= '0;
      pixel_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
      error   <= 1'b0;
    end else if (abort) begin
      x_cnt   <= '0;
      y_cnt   <= '0;
      idx     <= '0;
      timer   <= '0;
      pixel_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            error <= 1'b0;
            x_cnt <= '0;
            y_cnt <= '0;
            idx   <= '0;
          end
        end
        S_ISSUE: timer <= TIMER_ONE;
        S_WAIT: begin
          if (i_pixel_strobe) begin
            pixel_q <= i_pixel;
            x_q     <= x_cnt;
            y_q     <= y_cnt;
          end else if (timer_tc) begin
            error <= 1'b1;
          end else begin
            timer <= timer + TIMER_ONE;
          end
        end
        S_PRESENT: begin
          if (i_ready && !last_pixel) begin
            idx <= idx + ONE_16;
            if (x_cnt == X_LAST) begin
              x_cnt <= '0;
              y_cnt <= y_cnt + ONE_16;
            end else begin
              x_cnt <= x_cnt + ONE_16;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_coordinate_index = idx;
  assign o_pixel            = pixel_q;
  assign o_x                = x_q;
  assign o_y                = y_q;
  assign o_error            = error;

`ifdef FRAME_CHECKSUM_EN
  logic [15:0] checksum;

  // The sum holds after DONE so the final value stays readable until the next start.
  always_ff @(posedge clk) begin
    if (!reset)                          checksum <= '0;
    else if (abort)                      checksum <= '0;
    else if (state == S_IDLE && start)   checksum <= '0;
    else if (transfer)                   checksum <= checksum + 16'(pixel_q);
  end

  assign o_checksum = checksum;
`else
  logic unused_transfer;
  assign unused_transfer = transfer;
`endif

endmodule
